// File: rtl/garage_pkg.sv
// Shared definitions for the garage door controller: state and direction codes.
package garage_pkg;

    // Controller states; the numeric codes are visible on the State output.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MV_UP = 3'd1,
        MV_DN = 3'd2,
        STOP  = 3'd3,
        DEAD  = 3'd4,
        FAULT = 3'd5
    } state_e;

    // Travel direction, used for the last direction moved and the post-dead-time target.
    typedef enum logic {
        DIR_DN = 1'b0,
        DIR_UP = 1'b1
    } dir_e;

    // Reversal helper: the direction to head in after a pause.
    function automatic dir_e opposite(input dir_e d);
        return (d == DIR_UP) ? DIR_DN : DIR_UP;
    endfunction

endpackage

// File: rtl/garage_cycle_timer.sv
// Loadable down-counter with a zero flag; saturates at zero while enabled.
module garage_cycle_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: a load wins over counting down.
    always_comb begin
        // NOTE: default first so every path assigns count_d and no latch is inferred.
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments for state so every flop samples pre-edge values.
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/garage_door_ctrl.sv
// Garage door motor controller: edge-detected Activate, pause, obstacle
// auto-reverse, turnaround dead-time and travel-timeout fault.
module garage_door_ctrl
    import garage_pkg::*;
#(
    parameter int unsigned TRAVEL_TIMEOUT = 1000,
    parameter int unsigned DEAD_CYCLES    = 4,
    parameter bit          REVERSE_EN     = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Activate,
    input  logic       Up_MAX,
    input  logic       Dn_MAX,
    input  logic       Obstacle,
    input  logic       Fault_Clr,
    output logic       UP_M,
    output logic       DN_M,
    output logic       Fault,
    output logic       Busy,
    output logic [2:0] State
);

    localparam int unsigned TRAVEL_W = $clog2(TRAVEL_TIMEOUT);
    localparam int unsigned DEAD_W   = $clog2(DEAD_CYCLES + 1);
    // Down-counters reach zero on the last permitted cycle of the phase.
    localparam logic [TRAVEL_W-1:0] TRAVEL_LOAD = TRAVEL_W'(TRAVEL_TIMEOUT - 1);
    localparam logic [DEAD_W-1:0]   DEAD_LOAD   = DEAD_W'(DEAD_CYCLES - 1);

    state_e state_q, state_d;
    dir_e   last_dir_q, last_dir_d;
    dir_e   target_q, target_d;
    logic   act_q;
    logic   act_p;
    logic   up_m_q, up_m_d;
    logic   dn_m_q, dn_m_d;
    logic   fault_q, fault_d;
    logic   busy_q, busy_d;
    logic   travel_load, travel_en, travel_zero;
    logic   dead_load, dead_zero;

    assign act_p = Activate & ~act_q;

    // Travel timer restarts on every entry into a moving state.
    assign travel_load = ((state_d == MV_UP) || (state_d == MV_DN)) && (state_d != state_q);
    assign travel_en   = (state_q == MV_UP) || (state_q == MV_DN);
    assign dead_load   = (state_d == DEAD) && (state_q != DEAD);

    garage_cycle_timer #(.WIDTH(TRAVEL_W)) u_travel_timer (
        .clk      (CLK),
        .rst      (RST),
        .load     (travel_load),
        .load_val (TRAVEL_LOAD),
        .en       (travel_en),
        .zero     (travel_zero)
    );

    garage_cycle_timer #(.WIDTH(DEAD_W)) u_dead_timer (
        .clk      (CLK),
        .rst      (RST),
        .load     (dead_load),
        .load_val (DEAD_LOAD),
        .en       (state_q == DEAD),
        .zero     (dead_zero)
    );

    // Next-state, direction bookkeeping and Moore output decode of the next state.
    always_comb begin
        state_d    = state_q;
        last_dir_d = last_dir_q;
        target_d   = target_q;
        unique case (state_q)
            IDLE: begin
                if (act_p) begin
                    if (Up_MAX && Dn_MAX) begin
                        state_d = FAULT;
                    end else if (Dn_MAX) begin
                        state_d = MV_UP;
                    end else begin
                        state_d = MV_DN;
                    end
                end
            end
            MV_UP: begin
                if (Up_MAX) begin
                    state_d = IDLE;
                end else if (travel_zero) begin
                    state_d = FAULT;
                end else if (act_p) begin
                    state_d    = STOP;
                    last_dir_d = DIR_UP;
                end
            end
            MV_DN: begin
                if (Dn_MAX) begin
                    state_d = IDLE;
                end else if (Obstacle) begin
                    last_dir_d = DIR_DN;
                    if (REVERSE_EN) begin
                        state_d  = DEAD;
                        target_d = DIR_UP;
                    end else begin
                        state_d = STOP;
                    end
                end else if (travel_zero) begin
                    state_d = FAULT;
                end else if (act_p) begin
                    state_d    = STOP;
                    last_dir_d = DIR_DN;
                end
            end
            STOP: begin
                if (act_p) begin
                    state_d  = DEAD;
                    target_d = opposite(last_dir_q);
                end
            end
            DEAD: begin
                if (dead_zero) begin
                    state_d = (target_q == DIR_UP) ? MV_UP : MV_DN;
                end
            end
            FAULT: begin
                if (Fault_Clr) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        up_m_d  = (state_d == MV_UP);
        dn_m_d  = (state_d == MV_DN);
        fault_d = (state_d == FAULT);
        busy_d  = (state_d == MV_UP) || (state_d == MV_DN) || (state_d == DEAD);
    end

    // State, edge-detect and registered outputs; reset drops the motors at once.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            last_dir_q <= DIR_DN;
            target_q   <= DIR_DN;
            act_q      <= 1'b0;
            up_m_q     <= 1'b0;
            dn_m_q     <= 1'b0;
            fault_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_dir_q <= last_dir_d;
            target_q   <= target_d;
            act_q      <= Activate;
            up_m_q     <= up_m_d;
            dn_m_q     <= dn_m_d;
            fault_q    <= fault_d;
            busy_q     <= busy_d;
        end
    end

    assign UP_M  = up_m_q;
    assign DN_M  = dn_m_q;
    assign Fault = fault_q;
    assign Busy  = busy_q;
    assign State = state_q;

endmodule

// File: tb/tb_garage_door_ctrl.sv
// Self-checking bench: two controllers (auto-reverse on and off) share stimulus;
// expected output words come from hand-derived vector tables via a scoreboard queue.
module tb_garage_door_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       Activate, Up_MAX, Dn_MAX, Obstacle, Fault_Clr;
    logic       up_a, dn_a, fault_a, busy_a;
    logic [2:0] state_a;
    logic       up_b, dn_b, fault_b, busy_b;
    logic [2:0] state_b;

    // Output word layout: {UP_M, DN_M, Fault, Busy, State[2:0]}.
    localparam logic [6:0] O_IDLE  = 7'b0000_000;
    localparam logic [6:0] O_UP    = 7'b1001_001;
    localparam logic [6:0] O_DN    = 7'b0101_010;
    localparam logic [6:0] O_STOP  = 7'b0000_011;
    localparam logic [6:0] O_DEAD  = 7'b0001_100;
    localparam logic [6:0] O_FAULT = 7'b0010_101;

    typedef struct {
        bit         act;
        bit         up;
        bit         dn;
        bit         obst;
        bit         fclr;
        logic [6:0] exp_a;
        logic [6:0] exp_b;
        bit         use_b;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    garage_door_ctrl #(.TRAVEL_TIMEOUT(20), .DEAD_CYCLES(3), .REVERSE_EN(1'b1)) dut_a (
        .CLK(CLK), .RST(RST), .Activate(Activate), .Up_MAX(Up_MAX), .Dn_MAX(Dn_MAX),
        .Obstacle(Obstacle), .Fault_Clr(Fault_Clr),
        .UP_M(up_a), .DN_M(dn_a), .Fault(fault_a), .Busy(busy_a), .State(state_a)
    );

    garage_door_ctrl #(.TRAVEL_TIMEOUT(20), .DEAD_CYCLES(3), .REVERSE_EN(1'b0)) dut_b (
        .CLK(CLK), .RST(RST), .Activate(Activate), .Up_MAX(Up_MAX), .Dn_MAX(Dn_MAX),
        .Obstacle(Obstacle), .Fault_Clr(Fault_Clr),
        .UP_M(up_b), .DN_M(dn_b), .Fault(fault_b), .Busy(busy_b), .State(state_b)
    );

    always #5 CLK = ~CLK;

    function automatic logic [6:0] obs_a();
        return {up_a, dn_a, fault_a, busy_a, state_a};
    endfunction

    function automatic logic [6:0] obs_b();
        return {up_b, dn_b, fault_b, busy_b, state_b};
    endfunction

    // Row where both controllers are expected to behave identically.
    function automatic vec_t row(input bit a, input bit u, input bit d, input bit o,
                                 input bit f, input logic [6:0] ea);
        vec_t v;
        v = '{act: a, up: u, dn: d, obst: o, fclr: f, exp_a: ea, exp_b: ea, use_b: 1'b0};
        return v;
    endfunction

    // Row where the no-reverse controller has its own expectation.
    function automatic vec_t row_b(input bit a, input bit u, input bit d, input bit o,
                                   input bit f, input logic [6:0] ea, input logic [6:0] eb);
        vec_t v;
        v = '{act: a, up: u, dn: d, obst: o, fclr: f, exp_a: ea, exp_b: eb, use_b: 1'b1};
        return v;
    endfunction

    task automatic check(input string name, input logic [6:0] actual, input logic [6:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    // Drive one vector, queue its expectation, compare after the clock edge.
    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        @(negedge CLK);
        Activate  = v.act;
        Up_MAX    = v.up;
        Dn_MAX    = v.dn;
        Obstacle  = v.obst;
        Fault_Clr = v.fclr;
        exp_q.push_back(v);
        @(posedge CLK);
        #1;
        e = exp_q.pop_front();
        check({tag, "/a"}, obs_a(), e.exp_a);
        check({tag, "/b"}, obs_b(), e.use_b ? e.exp_b : e.exp_a);
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("%s[%0d]", tag, i));
        end
        tbl.delete();
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST       = 1'b1;
        Activate  = 1'b0;
        Up_MAX    = 1'b0;
        Dn_MAX    = 1'b0;
        Obstacle  = 1'b0;
        Fault_Clr = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST       = 1'b1;
        Activate  = 1'b0;
        Up_MAX    = 1'b0;
        Dn_MAX    = 1'b0;
        Obstacle  = 1'b0;
        Fault_Clr = 1'b0;
        #12;
        check("reset/a", obs_a(), O_IDLE);
        check("reset/b", obs_b(), O_IDLE);
        @(negedge CLK);
        RST = 1'b0;

        // Open from closed with Activate held: one start only, stop at the open limit.
        tbl.push_back(row(1, 0, 1, 0, 0, O_UP));
        for (int i = 0; i < 4; i++) tbl.push_back(row(1, 0, 0, 0, 0, O_UP));
        for (int i = 0; i < 2; i++) tbl.push_back(row(0, 0, 0, 0, 0, O_UP));
        for (int i = 0; i < 3; i++) tbl.push_back(row(0, 1, 0, 0, 0, O_IDLE));
        run_table("open");

        // Close, then obstacle: reverse after three dead cycles, or stop for good.
        tbl.push_back(row(1, 1, 0, 0, 0, O_DN));
        tbl.push_back(row(0, 0, 0, 0, 0, O_DN));
        tbl.push_back(row(0, 0, 0, 0, 0, O_DN));
        tbl.push_back(row_b(0, 0, 0, 1, 0, O_DEAD, O_STOP));
        tbl.push_back(row_b(0, 0, 0, 1, 0, O_DEAD, O_STOP));
        tbl.push_back(row_b(0, 0, 0, 0, 0, O_DEAD, O_STOP));
        tbl.push_back(row_b(0, 0, 0, 0, 0, O_UP, O_STOP));
        tbl.push_back(row_b(0, 0, 0, 1, 0, O_UP, O_STOP));
        for (int i = 0; i < 4; i++) tbl.push_back(row_b(0, 1, 0, 0, 0, O_IDLE, O_STOP));
        run_table("obstacle");

        // Pause while opening, resume reverses downward after the dead time.
        do_reset();
        tbl.push_back(row(1, 0, 1, 0, 0, O_UP));
        for (int i = 0; i < 3; i++) tbl.push_back(row(0, 0, 0, 0, 0, O_UP));
        tbl.push_back(row(1, 0, 0, 0, 0, O_STOP));
        tbl.push_back(row(0, 0, 0, 1, 0, O_STOP));
        tbl.push_back(row(1, 0, 0, 0, 0, O_DEAD));
        tbl.push_back(row(0, 0, 0, 0, 0, O_DEAD));
        tbl.push_back(row(0, 0, 0, 0, 0, O_DEAD));
        tbl.push_back(row(0, 0, 0, 0, 0, O_DN));
        tbl.push_back(row(0, 0, 0, 0, 0, O_DN));
        tbl.push_back(row(0, 0, 1, 0, 0, O_IDLE));
        run_table("pause");

        // Travel timeout: 20 cycles of DN_M, then FAULT; Activate ignored; Fault_Clr exits.
        do_reset();
        apply(row(1, 0, 0, 0, 0, O_DN), "tmo_start");
        for (int i = 1; i < 20; i++) begin
            apply(row(0, 0, 0, 0, (i == 10), O_DN), $sformatf("tmo_run[%0d]", i));
        end
        apply(row(0, 0, 0, 0, 0, O_FAULT), "tmo_fault");
        apply(row(1, 0, 0, 0, 0, O_FAULT), "tmo_act_ignored");
        apply(row(0, 0, 0, 0, 0, O_FAULT), "tmo_hold");
        apply(row(0, 0, 0, 0, 1, O_IDLE), "tmo_clear");
        apply(row(0, 0, 0, 0, 0, O_IDLE), "tmo_idle");

        // Limit switch on the final permitted cycle wins over the timeout.
        apply(row(1, 0, 0, 0, 0, O_DN), "lim_start");
        for (int i = 1; i < 20; i++) begin
            apply(row(0, 0, 0, 0, 0, O_DN), $sformatf("lim_run[%0d]", i));
        end
        apply(row(0, 0, 1, 0, 0, O_IDLE), "lim_wins");

        // Both limits asserted: sensor conflict goes straight to FAULT.
        do_reset();
        apply(row(1, 1, 1, 0, 0, O_FAULT), "conflict");
        apply(row(0, 1, 1, 0, 0, O_FAULT), "conflict_hold");
        apply(row(1, 1, 1, 0, 0, O_FAULT), "conflict_act");
        apply(row(0, 1, 1, 0, 1, O_IDLE), "conflict_clear");

        // Asynchronous reset while opening drops the motor before the next edge.
        do_reset();
        apply(row(1, 0, 1, 0, 0, O_UP), "areset_start");
        apply(row(0, 0, 0, 0, 0, O_UP), "areset_run");
        #3;
        RST = 1'b1;
        #1;
        check("areset_async/a", obs_a(), O_IDLE);
        check("areset_async/b", obs_b(), O_IDLE);
        @(negedge CLK);
        RST = 1'b0;
        apply(row(0, 0, 0, 0, 0, O_IDLE), "areset_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
